// File: rtl/vid_timing_gen.sv
// Video timing generator for the HDMI transmit path.
// Produces pixel/line counters, polarity-applied HSYNC/VSYNC, DE and frame/line
// markers. A new mode is offered through a valid/ready port, validated on
// capture, held in a shadow copy and switched in only on the last pixel of a
// frame so the output never tears.
module vid_timing_gen #(
    parameter int CW       = 12,
    parameter int PIPE     = 2,
    parameter int DEF_HACT = 1920,
    parameter int DEF_HFP  = 88,
    parameter int DEF_HSW  = 44,
    parameter int DEF_HBP  = 148,
    parameter int DEF_VACT = 1080,
    parameter int DEF_VFP  = 4,
    parameter int DEF_VSW  = 5,
    parameter int DEF_VBP  = 36,
    parameter int DEF_HPOL = 1,
    parameter int DEF_VPOL = 1
) (
    input  logic          pclk,
    input  logic          rst_,
    input  logic          en,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_hact,
    input  logic [CW-1:0] cfg_hfp,
    input  logic [CW-1:0] cfg_hsw,
    input  logic [CW-1:0] cfg_hbp,
    input  logic [CW-1:0] cfg_vact,
    input  logic [CW-1:0] cfg_vfp,
    input  logic [CW-1:0] cfg_vsw,
    input  logic [CW-1:0] cfg_vbp,
    input  logic          cfg_hpol,
    input  logic          cfg_vpol,
    output logic          cfg_err,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          sof,
    output logic          eol
);

    // Totals are summed two bits wider so four full-scale fields cannot wrap.
    localparam int TW = CW + 2;
    localparam logic [TW-1:0] LIMIT = {2'b01, {CW{1'b0}}};

    localparam logic [CW-1:0] D_HACT = CW'(DEF_HACT);
    localparam logic [CW-1:0] D_HFP  = CW'(DEF_HFP);
    localparam logic [CW-1:0] D_HSW  = CW'(DEF_HSW);
    localparam logic [CW-1:0] D_HBP  = CW'(DEF_HBP);
    localparam logic [CW-1:0] D_VACT = CW'(DEF_VACT);
    localparam logic [CW-1:0] D_VFP  = CW'(DEF_VFP);
    localparam logic [CW-1:0] D_VSW  = CW'(DEF_VSW);
    localparam logic [CW-1:0] D_VBP  = CW'(DEF_VBP);
    localparam logic          D_HPOL = (DEF_HPOL != 0);
    localparam logic          D_VPOL = (DEF_VPOL != 0);

    // Decoded bundle order: {hsync, vsync, de, sof, eol}; idle value has syncs inactive.
    localparam logic [4:0] RST_VEC = {~D_HPOL, ~D_VPOL, 3'b000};

    function automatic logic [TW-1:0] sum4(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c, input logic [CW-1:0] d);
        return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    endfunction

    // Active mode
    logic [CW-1:0] hact_reg, hfp_reg, hsw_reg, hbp_reg;
    logic [CW-1:0] vact_reg, vfp_reg, vsw_reg, vbp_reg;
    logic          hpol_reg, vpol_reg;
    // Pending (shadow) mode
    logic [CW-1:0] sh_hact_reg, sh_hfp_reg, sh_hsw_reg, sh_hbp_reg;
    logic [CW-1:0] sh_vact_reg, sh_vfp_reg, sh_vsw_reg, sh_vbp_reg;
    logic          sh_hpol_reg, sh_vpol_reg;
    logic          pend_reg;
    logic          err_reg;

    logic [CW-1:0] hcount_reg, vcount_reg;

    logic [TW-1:0] htotal, vtotal, cfg_htotal, cfg_vtotal;
    logic [TW-1:0] h_ext, v_ext;
    logic          last_h, last_v, apply, capture, cfg_bad;
    logic [4:0]    raw_vec, out_vec;

    assign htotal     = sum4(hact_reg, hfp_reg, hsw_reg, hbp_reg);
    assign vtotal     = sum4(vact_reg, vfp_reg, vsw_reg, vbp_reg);
    assign cfg_htotal = sum4(cfg_hact, cfg_hfp, cfg_hsw, cfg_hbp);
    assign cfg_vtotal = sum4(cfg_vact, cfg_vfp, cfg_vsw, cfg_vbp);
    assign h_ext      = {2'b00, hcount_reg};
    assign v_ext      = {2'b00, vcount_reg};

    // ">=" rather than "==" so a counter can never run away past the wrap point.
    assign last_h  = (h_ext >= htotal - TW'(1));
    assign last_v  = (v_ext >= vtotal - TW'(1));
    assign apply   = en & pend_reg & last_h & last_v;
    assign capture = cfg_valid & ~pend_reg;
    assign cfg_bad = (cfg_hact == '0) | (cfg_hsw == '0) | (cfg_vact == '0) | (cfg_vsw == '0) |
                     (cfg_htotal > LIMIT) | (cfg_vtotal > LIMIT);

    assign cfg_ready = ~pend_reg;
    assign cfg_err   = err_reg;
    assign hcount    = hcount_reg;
    assign vcount    = vcount_reg;

    // Pixel/line counters; a frame wrap lands on (0,0) whether or not a new mode is applied.
    always_ff @(posedge pclk or negedge rst_) begin
        if (!rst_) begin
            hcount_reg <= '0;
            vcount_reg <= '0;
        end else if (en) begin
            if (last_h) begin
                hcount_reg <= '0;
                vcount_reg <= last_v ? '0 : vcount_reg + CW'(1);
            end else begin
                hcount_reg <= hcount_reg + CW'(1);
            end
        end
    end

    // Mode handshake: validate and capture into the shadow, switch in at frame end.
    always_ff @(posedge pclk or negedge rst_) begin
        if (!rst_) begin
            hact_reg <= D_HACT; hfp_reg <= D_HFP; hsw_reg <= D_HSW; hbp_reg <= D_HBP;
            vact_reg <= D_VACT; vfp_reg <= D_VFP; vsw_reg <= D_VSW; vbp_reg <= D_VBP;
            hpol_reg <= D_HPOL; vpol_reg <= D_VPOL;
            sh_hact_reg <= '0; sh_hfp_reg <= '0; sh_hsw_reg <= '0; sh_hbp_reg <= '0;
            sh_vact_reg <= '0; sh_vfp_reg <= '0; sh_vsw_reg <= '0; sh_vbp_reg <= '0;
            sh_hpol_reg <= 1'b0; sh_vpol_reg <= 1'b0;
            pend_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            if (apply) begin
                hact_reg <= sh_hact_reg; hfp_reg <= sh_hfp_reg;
                hsw_reg  <= sh_hsw_reg;  hbp_reg <= sh_hbp_reg;
                vact_reg <= sh_vact_reg; vfp_reg <= sh_vfp_reg;
                vsw_reg  <= sh_vsw_reg;  vbp_reg <= sh_vbp_reg;
                hpol_reg <= sh_hpol_reg; vpol_reg <= sh_vpol_reg;
                pend_reg <= 1'b0;
            end else if (capture) begin
                if (cfg_bad) begin
                    err_reg <= 1'b1;
                end else begin
                    sh_hact_reg <= cfg_hact; sh_hfp_reg <= cfg_hfp;
                    sh_hsw_reg  <= cfg_hsw;  sh_hbp_reg <= cfg_hbp;
                    sh_vact_reg <= cfg_vact; sh_vfp_reg <= cfg_vfp;
                    sh_vsw_reg  <= cfg_vsw;  sh_vbp_reg <= cfg_vbp;
                    sh_hpol_reg <= cfg_hpol; sh_vpol_reg <= cfg_vpol;
                    pend_reg    <= 1'b1;
                end
            end
        end
    end

    // Decode sync/DE/markers for the pixel the counters currently point at.
    always_comb begin
        logic de_b, hs_b, vs_b;
        de_b = (h_ext < {2'b00, hact_reg}) && (v_ext < {2'b00, vact_reg});
        hs_b = (h_ext >= {2'b00, hact_reg} + {2'b00, hfp_reg}) &&
               (h_ext <  {2'b00, hact_reg} + {2'b00, hfp_reg} + {2'b00, hsw_reg});
        vs_b = (v_ext >= {2'b00, vact_reg} + {2'b00, vfp_reg}) &&
               (v_ext <  {2'b00, vact_reg} + {2'b00, vfp_reg} + {2'b00, vsw_reg});
        raw_vec = {hpol_reg ? hs_b : ~hs_b,
                   vpol_reg ? vs_b : ~vs_b,
                   de_b,
                   (hcount_reg == '0) && (vcount_reg == '0),
                   (h_ext == htotal - TW'(1))};
    end

    generate
        if (PIPE == 0) begin : g_nopipe
            assign out_vec = raw_vec;
        end else begin : g_pipe
            logic [4:0] pipe_reg [PIPE];
            // Delay line aligning decoded outputs with the pixel source latency.
            always_ff @(posedge pclk or negedge rst_) begin
                if (!rst_) begin
                    for (int i = 0; i < PIPE; i++) pipe_reg[i] <= RST_VEC;
                end else if (en) begin
                    pipe_reg[0] <= raw_vec;
                    for (int i = 1; i < PIPE; i++) pipe_reg[i] <= pipe_reg[i-1];
                end
            end
            assign out_vec = pipe_reg[PIPE-1];
        end
    endgenerate

    assign {hsync, vsync, de, sof, eol} = out_vec;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: a small-geometry instance checked cycle by cycle
// against a frame-position reference model, plus a full 1080p instance
// checked over its first line.
module tb_vid_timing_gen;

    localparam int CW   = 8;
    localparam int PIPE = 2;
    localparam int LIM  = 1 << CW;

    typedef struct {
        int hact, hfp, hsw, hbp, vact, vfp, vsw, vbp;
        bit hpol, vpol;
    } mode_t;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic          rst_, en, cfg_valid, cfg_ready, cfg_err;
    logic [CW-1:0] cfg_hact, cfg_hfp, cfg_hsw, cfg_hbp, cfg_vact, cfg_vfp, cfg_vsw, cfg_vbp;
    logic          cfg_hpol, cfg_vpol;
    logic [CW-1:0] hcount, vcount;
    logic          hsync, vsync, de, sof, eol;

    // Full-size default instance (first line only)
    logic [11:0] d_zero;
    logic        d_one, d_low, d_ready, d_err, d_hs, d_vs, d_de, d_sof, d_eol;
    logic [11:0] d_hc, d_vc;

    vid_timing_gen #(
        .CW(CW), .PIPE(PIPE),
        .DEF_HACT(16), .DEF_HFP(4), .DEF_HSW(3), .DEF_HBP(5),
        .DEF_VACT(10), .DEF_VFP(2), .DEF_VSW(2), .DEF_VBP(3),
        .DEF_HPOL(1), .DEF_VPOL(1)
    ) dut (
        .pclk(pclk), .rst_(rst_), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_hact(cfg_hact), .cfg_hfp(cfg_hfp), .cfg_hsw(cfg_hsw), .cfg_hbp(cfg_hbp),
        .cfg_vact(cfg_vact), .cfg_vfp(cfg_vfp), .cfg_vsw(cfg_vsw), .cfg_vbp(cfg_vbp),
        .cfg_hpol(cfg_hpol), .cfg_vpol(cfg_vpol), .cfg_err(cfg_err),
        .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .de(de), .sof(sof), .eol(eol)
    );

    vid_timing_gen dut_def (
        .pclk(pclk), .rst_(rst_), .en(d_one),
        .cfg_valid(d_low), .cfg_ready(d_ready),
        .cfg_hact(d_zero), .cfg_hfp(d_zero), .cfg_hsw(d_zero), .cfg_hbp(d_zero),
        .cfg_vact(d_zero), .cfg_vfp(d_zero), .cfg_vsw(d_zero), .cfg_vbp(d_zero),
        .cfg_hpol(d_low), .cfg_vpol(d_low), .cfg_err(d_err),
        .hcount(d_hc), .vcount(d_vc),
        .hsync(d_hs), .vsync(d_vs), .de(d_de), .sof(d_sof), .eol(d_eol)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: mode in force, pending mode, linear position within the frame
    mode_t    m_mode, p_mode, offer_m;
    bit       m_pend, m_err;
    int       m_n;
    bit [4:0] exp_q[$];

    function automatic mode_t mk(int a, int b, int c, int d, int e, int f, int g, int h,
                                 bit hp, bit vp);
        mode_t m;
        m.hact = a; m.hfp = b; m.hsw = c; m.hbp = d;
        m.vact = e; m.vfp = f; m.vsw = g; m.vbp = h;
        m.hpol = hp; m.vpol = vp;
        return m;
    endfunction

    function automatic mode_t def_mode();
        return mk(16, 4, 3, 5, 10, 2, 2, 3, 1'b1, 1'b1);
    endfunction

    function automatic int htot(mode_t m);
        return m.hact + m.hfp + m.hsw + m.hbp;
    endfunction

    function automatic int vtot(mode_t m);
        return m.vact + m.vfp + m.vsw + m.vbp;
    endfunction

    function automatic bit is_bad(mode_t m);
        return (m.hact == 0) || (m.hsw == 0) || (m.vact == 0) || (m.vsw == 0) ||
               (htot(m) > LIM) || (vtot(m) > LIM);
    endfunction

    // Expected {hsync, vsync, de, sof, eol} for pixel (h, v) of mode m
    function automatic bit [4:0] decode(mode_t m, int h, int v);
        bit de_b, hs, vs;
        de_b = (h < m.hact) && (v < m.vact);
        hs   = (h >= m.hact + m.hfp) && (h < m.hact + m.hfp + m.hsw);
        vs   = (v >= m.vact + m.vfp) && (v < m.vact + m.vfp + m.vsw);
        return {m.hpol ? hs : !hs, m.vpol ? vs : !vs, de_b, (h == 0) && (v == 0),
                h == htot(m) - 1};
    endfunction

    task automatic model_reset();
        m_mode = def_mode();
        m_pend = 0;
        m_err  = 0;
        m_n    = 0;
        exp_q.delete();
        for (int i = 0; i < PIPE; i++) exp_q.push_back(5'b00000);
    endtask

    function automatic logic [2*CW+6:0] exp_vec();
        int ht;
        ht = htot(m_mode);
        return {CW'(m_n % ht), CW'(m_n / ht), exp_q[0], !m_pend, m_err};
    endfunction

    function automatic logic [2*CW+6:0] dut_vec();
        return {hcount, vcount, hsync, vsync, de, sof, eol, cfg_ready, cfg_err};
    endfunction

    // Advance the model by one clock with the inputs currently driven, then
    // let the DUT take the same edge; returns at the following falling edge.
    task automatic step();
        bit pend_old;
        int ht, vt;
        pend_old = m_pend;
        ht = htot(m_mode);
        vt = vtot(m_mode);
        m_err = 0;
        if (en) begin
            exp_q.push_back(decode(m_mode, m_n % ht, m_n / ht));
            exp_q.delete(0);
            if (m_n == ht * vt - 1) begin
                m_n = 0;
                if (pend_old) begin
                    m_mode = p_mode;
                    m_pend = 0;
                end
            end else begin
                m_n++;
            end
        end
        if (cfg_valid && !pend_old) begin
            if (is_bad(offer_m)) m_err = 1;
            else begin
                p_mode = offer_m;
                m_pend = 1;
            end
        end
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic offer(mode_t m);
        offer_m  = m;
        cfg_hact = CW'(m.hact); cfg_hfp = CW'(m.hfp); cfg_hsw = CW'(m.hsw); cfg_hbp = CW'(m.hbp);
        cfg_vact = CW'(m.vact); cfg_vfp = CW'(m.vfp); cfg_vsw = CW'(m.vsw); cfg_vbp = CW'(m.vbp);
        cfg_hpol = m.hpol; cfg_vpol = m.vpol;
        cfg_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_ = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        d_zero = '0; d_one = 1'b1; d_low = 1'b0;
        offer(def_mode());
        cfg_valid = 1'b0;
        repeat (3) @(negedge pclk);
        model_reset();
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset: actual=%h expected=%h", dut_vec(), exp_vec());
        end
        checks++;
        if ({d_hc, d_vc, d_hs, d_vs, d_de, d_sof, d_eol, d_ready, d_err} !== {24'd0, 7'b0000010}) begin
            errors++;
            $display("FAIL reset_1080p: actual=%h expected=%h",
                     {d_hc, d_vc, d_hs, d_vs, d_de, d_sof, d_eol, d_ready, d_err}, {24'd0, 7'b0000010});
        end
        checks++;
        rst_ = 1'b1;
    endtask

    // First line and a bit of the full-size 1080p instance
    task automatic test_default_1080p();
        logic [27:0] act, expv;
        int p, hp;
        en = 1'b1;
        for (int k = 1; k <= 2250; k++) begin
            step();
            p  = k - PIPE;
            hp = p % 2200;
            expv = {12'(k % 2200), 12'(k / 2200), 4'b0000};
            if (p >= 0) begin
                expv[3] = (hp >= 2008) && (hp < 2052);
                expv[1] = (hp < 1920);
            end
            act = {d_hc, d_vc, d_hs, d_vs, d_de, 1'b0};
            if (act !== expv) begin
                errors++;
                $display("FAIL default_1080p k=%0d: actual=%h expected=%h", k, act, expv);
            end
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL defaults_small k=%0d: actual=%h expected=%h", k, dut_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_defaults();
        int de_cnt, sof_cnt;
        de_cnt = 0; sof_cnt = 0;
        for (int i = 0; i < 2 * 476; i++) begin
            step();
            de_cnt  += int'(de);
            sof_cnt += int'(sof);
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL defaults i=%0d: actual=%h expected=%h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
        if (de_cnt !== 2 * 16 * 10) begin
            errors++;
            $display("FAIL de_count: actual=%0d expected=%0d", de_cnt, 320);
        end
        checks++;
        if (sof_cnt !== 2) begin
            errors++;
            $display("FAIL sof_count: actual=%0d expected=2", sof_cnt);
        end
        checks++;
    endtask

    task automatic test_mode_change();
        int sof_cnt, eol_cnt;
        for (int i = 0; i < 28 && (m_n % 28) != 10; i++) step();
        offer(mk(12, 2, 3, 3, 6, 1, 2, 2, 1'b1, 1'b1));
        step();
        cfg_valid = 1'b0;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL mode_accept: cfg_ready actual=%b expected=0", cfg_ready);
        end
        checks++;
        for (int i = 0; i < 1200 && m_pend; i++) begin
            step();
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL mode_wait i=%0d: actual=%h expected=%h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
        sof_cnt = 0; eol_cnt = 0;
        for (int i = 0; i < 220; i++) begin
            step();
            sof_cnt += int'(sof);
            eol_cnt += int'(eol);
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL mode_new i=%0d: actual=%h expected=%h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
        if (sof_cnt !== 1 || eol_cnt !== 11) begin
            errors++;
            $display("FAIL mode_markers: actual sof=%0d eol=%0d expected sof=1 eol=11", sof_cnt, eol_cnt);
        end
        checks++;
    endtask

    task automatic test_reject();
        mode_t bad[6];
        bad[0] = mk(16, 4, 0, 5, 10, 2, 2, 3, 1'b1, 1'b1);
        bad[1] = mk(0, 4, 3, 5, 10, 2, 2, 3, 1'b1, 1'b1);
        bad[2] = mk(16, 4, 3, 5, 0, 2, 2, 3, 1'b1, 1'b1);
        bad[3] = mk(16, 4, 3, 5, 10, 2, 0, 3, 1'b1, 1'b1);
        bad[4] = mk(250, 3, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1);
        bad[5] = mk(4, 1, 1, 1, 250, 3, 2, 2, 1'b1, 1'b1);
        for (int b = 0; b < 6; b++) begin
            offer(bad[b]);
            step();
            cfg_valid = 1'b0;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reject_pulse b=%0d: actual=%h expected=%h", b, dut_vec(), exp_vec());
            end
            checks++;
            step();
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reject_clear b=%0d: actual=%h expected=%h", b, dut_vec(), exp_vec());
            end
            checks++;
        end
        // Exactly 2^CW pixels per line is still legal
        offer(mk(250, 2, 2, 2, 2, 1, 1, 1, 1'b1, 1'b1));
        step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 1500 && m_pend; i++) begin
            step();
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL max_wait i=%0d: actual=%h expected=%h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
        for (int i = 0; i < 300; i++) begin
            step();
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL max_line i=%0d: actual=%h expected=%h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_polarity();
        int hs_low, vs_low;
        offer(mk(16, 4, 3, 5, 10, 2, 2, 3, 1'b0, 1'b0));
        step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 2000 && m_pend; i++) begin
            step();
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL pol_wait i=%0d: actual=%h expected=%h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
        repeat (PIPE) step();
        hs_low = 0; vs_low = 0;
        for (int i = 0; i < 476; i++) begin
            step();
            hs_low += int'(!hsync);
            vs_low += int'(!vsync);
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL polarity i=%0d: actual=%h expected=%h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
        if (hs_low !== 3 * 17 || vs_low !== 2 * 28) begin
            errors++;
            $display("FAIL pol_counts: actual hs_low=%0d vs_low=%0d expected 51 56", hs_low, vs_low);
        end
        checks++;
    endtask

    task automatic test_en_freeze();
        int last;
        offer(def_mode());
        step();
        cfg_valid = 1'b0;
        last = htot(m_mode) * vtot(m_mode) - 1;
        for (int i = 0; i < 1000 && m_n != last; i++) step();
        if (m_n != last || !m_pend) begin
            errors++;
            $display("FAIL freeze_reach: actual pos=%0d pend=%0d expected pos=%0d pend=1", m_n, m_pend, last);
        end
        checks++;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL freeze i=%0d: actual=%h expected=%h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL freeze_apply i=%0d: actual=%h expected=%h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            cfg_valid = 1'b0;
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0)
                offer(mk($urandom_range(0, 20), $urandom_range(0, 5), $urandom_range(0, 4),
                         $urandom_range(0, 5), $urandom_range(0, 8), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
            step();
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random i=%0d: actual=%h expected=%h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
        cfg_valid = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_async_reset();
        if (!m_pend) begin
            offer(mk(12, 2, 3, 3, 6, 1, 2, 2, 1'b0, 1'b1));
            step();
            cfg_valid = 1'b0;
        end
        for (int i = 0; i < 40 && (m_n % htot(m_mode)) != 5; i++) step();
        #2 rst_ = 1'b0;
        #1 model_reset();
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL async_reset: actual=%h expected=%h", dut_vec(), exp_vec());
        end
        checks++;
        @(negedge pclk);
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_hold: actual=%h expected=%h", dut_vec(), exp_vec());
        end
        checks++;
        rst_ = 1'b1;
        for (int i = 0; i < 500; i++) begin
            step();
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL after_reset i=%0d: actual=%h expected=%h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_default_1080p();
        test_defaults();
        test_mode_change();
        test_reject();
        test_polarity();
        test_en_freeze();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
